reg_scoreboard: RTL and testbench

- Issue controller between decode and execute stages; holds one decoded instruction in a buffer and issues it only when its source registers have no in-flight writes.
- Tracks per-register pending-write counts: incremented at issue, decremented on writeback/retire report.
- Replaces "issue blindly" sequencing; decode's control bundle passes through as opaque payload.

---
 rtl/reg_scoreboard_pkg.sv | 12 +
 rtl/reg_scoreboard_counter.sv | 30 +++
 rtl/reg_scoreboard.sv | 111 +++++++++++
 tb/tb_reg_scoreboard.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing for the register scoreboard: architectural register file
// shape, pending-counter width and operand-use bit positions.
package reg_scoreboard_pkg;
    localparam int REGNO     = 8;
    localparam int REGNO_LOG = 3;
    localparam int SB_CNT_W  = 2;
    localparam int PAYLOAD_W = 64;
    localparam int PERF_W    = 16;

    localparam int OP_L = 0;
    localparam int OP_R = 1;
endpackage

// File: rtl/reg_scoreboard_counter.sv
// Per-register in-flight write counter; flags zero, full and a decrement at zero.
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_zero,
    output logic o_max,
    output logic o_underflow
);
    logic [CNT_W-1:0] cnt;

    assign o_zero      = (cnt == '0);
    assign o_max       = &cnt;
    assign o_underflow = i_dec & o_zero;

    // inc at max never arrives: the issuer holds any writer to a full register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt <= '0;
        else if (i_inc & ~i_dec)
            cnt <= cnt + 1'b1;
        else if (i_dec & ~i_inc & ~o_zero)
            cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/reg_scoreboard.sv
// Single-entry issue buffer between decode and execute; holds an instruction
// until no source has an in-flight write and its destination counter has room.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int RN    = REGNO,
    parameter int RN_LOG = REGNO_LOG,
    parameter int CNT_W = SB_CNT_W,
    parameter int PW    = PAYLOAD_W,
    parameter int PFW   = PERF_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_submit,
    output logic              o_ready,
    input  logic [PW-1:0]     i_payload,
    input  logic [RN_LOG-1:0] i_l_reg_sel,
    input  logic [RN_LOG-1:0] i_r_reg_sel,
    input  logic [1:0]        i_used_operands,
    input  logic [RN-1:0]     i_rf_ie,
    output logic              o_submit,
    output logic [PW-1:0]     o_payload,
    output logic [RN-1:0]     o_rf_ie,
    input  logic              i_next_ready,
    input  logic              i_flush,
    input  logic              i_wb_valid,
    input  logic [RN-1:0]     i_wb_rf_ie,
    output logic [RN-1:0]     o_pending,
    output logic              o_underflow,
    output logic [PFW-1:0]    o_stall_cnt
);
    logic              buf_valid;
    logic [PW-1:0]     buf_payload;
    logic [RN_LOG-1:0] buf_l_sel;
    logic [RN_LOG-1:0] buf_r_sel;
    logic [1:0]        buf_used;
    logic [RN-1:0]     buf_rf_ie;

    logic [RN-1:0] zero_v;
    logic [RN-1:0] max_v;
    logic [RN-1:0] uf_v;
    logic          hazard;
    logic          issue_now;
    logic          accept;

    // destination is one-hot, so the full-counter test is a masked OR
    assign hazard    = buf_valid & ((buf_used[OP_L] & ~zero_v[buf_l_sel]) |
                                    (buf_used[OP_R] & ~zero_v[buf_r_sel]) |
                                    (|(buf_rf_ie & max_v)));
    assign issue_now = buf_valid & ~hazard & i_next_ready & ~i_flush;
    assign o_ready   = ~buf_valid | issue_now;
    assign accept    = i_submit & o_ready & ~i_flush;
    assign o_pending = ~zero_v;

    genvar d;
    generate
        for (d = 0; d < RN; d++) begin : g_cnt
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_inc      (issue_now & buf_rf_ie[d]),
                .i_dec      (i_wb_valid & i_wb_rf_ie[d]),
                .o_zero     (zero_v[d]),
                .o_max      (max_v[d]),
                .o_underflow(uf_v[d])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            buf_valid   <= 1'b0;
            buf_payload <= '0;
            buf_l_sel   <= '0;
            buf_r_sel   <= '0;
            buf_used    <= '0;
            buf_rf_ie   <= '0;
        end else if (i_flush) begin
            buf_valid <= 1'b0;
        end else if (accept) begin
            buf_valid   <= 1'b1;
            buf_payload <= i_payload;
            buf_l_sel   <= i_l_reg_sel;
            buf_r_sel   <= i_r_reg_sel;
            buf_used    <= i_used_operands;
            buf_rf_ie   <= i_rf_ie;
        end else if (issue_now) begin
            buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_submit    <= 1'b0;
            o_payload   <= '0;
            o_rf_ie     <= '0;
            o_underflow <= 1'b0;
            o_stall_cnt <= '0;
        end else begin
            o_submit <= issue_now;
            if (issue_now) begin
                o_payload <= buf_payload;
                o_rf_ie   <= buf_rf_ie;
            end
            if (|uf_v)
                o_underflow <= 1'b1;
            if (hazard & ~i_flush)
                o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scenarios plus a randomized phase, each cycle compared against a
// behavioural model built from integer counts and a queue of issued writes.
module tb_reg_scoreboard;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_submit;
    logic        o_ready;
    logic [63:0] i_payload;
    logic [2:0]  i_l_reg_sel;
    logic [2:0]  i_r_reg_sel;
    logic [1:0]  i_used_operands;
    logic [7:0]  i_rf_ie;
    logic        o_submit;
    logic [63:0] o_payload;
    logic [7:0]  o_rf_ie;
    logic        i_next_ready;
    logic        i_flush;
    logic        i_wb_valid;
    logic [7:0]  i_wb_rf_ie;
    logic [7:0]  o_pending;
    logic        o_underflow;
    logic [15:0] o_stall_cnt;

    int checks = 0;
    int failures = 0;

    // model state
    int          m_cnt[8];
    bit          m_bv;
    logic [63:0] m_bpay;
    int          m_bl, m_br;
    bit [1:0]    m_bu;
    bit [7:0]    m_brf;
    bit          m_osub;
    logic [63:0] m_opay;
    bit [7:0]    m_orf;
    bit          m_uf;
    logic [15:0] m_stall;
    bit [7:0]    inflight[$];

    reg_scoreboard dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_submit(i_submit), .o_ready(o_ready),
        .i_payload(i_payload), .i_l_reg_sel(i_l_reg_sel), .i_r_reg_sel(i_r_reg_sel),
        .i_used_operands(i_used_operands), .i_rf_ie(i_rf_ie), .o_submit(o_submit),
        .o_payload(o_payload), .o_rf_ie(o_rf_ie), .i_next_ready(i_next_ready),
        .i_flush(i_flush), .i_wb_valid(i_wb_valid), .i_wb_rf_ie(i_wb_rf_ie),
        .o_pending(o_pending), .o_underflow(o_underflow), .o_stall_cnt(o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [7:0] m_pending();
        bit [7:0] v = '0;
        for (int k = 0; k < 8; k++) v[k] = (m_cnt[k] != 0);
        return v;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 8; k++) m_cnt[k] = 0;
        m_bv = 0; m_bpay = '0; m_bl = 0; m_br = 0; m_bu = '0; m_brf = '0;
        m_osub = 0; m_opay = '0; m_orf = '0; m_uf = 0; m_stall = '0;
        inflight.delete();
    endfunction

    // one clock: check o_ready before the edge, outputs just after it
    task automatic step();
        bit hz, issue, ready, acc, inc, dec;
        @(negedge i_clk);
        hz = 0;
        if (m_bv) begin
            if (m_bu[0] && m_cnt[m_bl] != 0) hz = 1;
            if (m_bu[1] && m_cnt[m_br] != 0) hz = 1;
            for (int k = 0; k < 8; k++)
                if (m_brf[k] && m_cnt[k] == 3) hz = 1;
        end
        issue = m_bv && !hz && i_next_ready && !i_flush;
        ready = !m_bv || issue;
        acc   = i_submit && ready && !i_flush;
        chk("o_ready", o_ready, ready);
        for (int k = 0; k < 8; k++) begin
            inc = issue && m_brf[k];
            dec = i_wb_valid && i_wb_rf_ie[k];
            if (dec && m_cnt[k] == 0) m_uf = 1;
            m_cnt[k] = m_cnt[k] + int'(inc) - int'(dec);
            if (m_cnt[k] < 0) m_cnt[k] = 0;
        end
        if (m_bv && hz && !i_flush) m_stall = m_stall + 16'd1;
        m_osub = issue;
        if (issue) begin
            m_opay = m_bpay;
            m_orf  = m_brf;
            if (m_brf != 0) inflight.push_back(m_brf);
        end
        if (i_flush) m_bv = 0;
        else if (acc) begin
            m_bv = 1; m_bpay = i_payload; m_bl = i_l_reg_sel; m_br = i_r_reg_sel;
            m_bu = i_used_operands; m_brf = i_rf_ie;
        end else if (issue) m_bv = 0;
        @(posedge i_clk);
        #1;
        chk("o_submit", o_submit, m_osub);
        chk("o_payload", o_payload, m_opay);
        chk("o_rf_ie", o_rf_ie, m_orf);
        chk("o_pending", o_pending, m_pending());
        chk("o_underflow", o_underflow, m_uf);
        chk("o_stall_cnt", o_stall_cnt, m_stall);
    endtask

    task automatic drv(input bit sub, input int l, input int r, input bit [1:0] used,
                       input bit [7:0] rf, input bit wbv, input bit [7:0] wbrf);
        i_submit = sub; i_payload = {$urandom, $urandom};
        i_l_reg_sel = 3'(l); i_r_reg_sel = 3'(r); i_used_operands = used; i_rf_ie = rf;
        i_next_ready = 1'b1; i_flush = 1'b0; i_wb_valid = wbv; i_wb_rf_ie = wbrf;
        step();
    endtask

    task automatic idle();
        drv(0, 0, 0, 2'b00, 8'h00, 0, 8'h00);
    endtask

    initial begin
        i_rst = 1'b1;
        i_submit = 0; i_payload = '0; i_l_reg_sel = '0; i_r_reg_sel = '0;
        i_used_operands = '0; i_rf_ie = '0; i_next_ready = 0; i_flush = 0;
        i_wb_valid = 0; i_wb_rf_ie = '0;
        m_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_submit", o_submit, 1'b0);
        chk("rst_payload", o_payload, 64'h0);
        chk("rst_rf_ie", o_rf_ie, 8'h00);
        chk("rst_pending", o_pending, 8'h00);
        chk("rst_underflow", o_underflow, 1'b0);
        chk("rst_stall", o_stall_cnt, 16'h0);
        chk("rst_ready", o_ready, 1'b1);
        i_rst = 1'b0;

        // independent stream: r1 then r2 written, sources r3/r4
        drv(1, 3, 4, 2'b11, 8'h02, 0, 8'h00);
        drv(1, 3, 4, 2'b11, 8'h04, 0, 8'h00);
        chk("indep_first_issue", o_submit, 1'b1);
        idle();
        chk("indep_second_issue", o_submit, 1'b1);
        chk("indep_second_dst", o_rf_ie, 8'h04);
        idle();
        drv(0, 0, 0, 2'b00, 8'h00, 1, 8'h02);
        drv(0, 0, 0, 2'b00, 8'h00, 1, 8'h04);
        chk("indep_drained", o_pending, 8'h00);

        // RAW on r1
        drv(1, 0, 0, 2'b00, 8'h02, 0, 8'h00);
        drv(1, 1, 0, 2'b01, 8'h08, 0, 8'h00);
        repeat (3) idle();
        chk("raw_stall_cnt", o_stall_cnt, 16'd3);
        drv(0, 0, 0, 2'b00, 8'h00, 1, 8'h02);
        chk("raw_held_at_wb", o_submit, 1'b0);
        idle();
        chk("raw_issue_after_wb", o_submit, 1'b1);
        chk("raw_issue_dst", o_rf_ie, 8'h08);
        drv(0, 0, 0, 2'b00, 8'h00, 1, 8'h08);

        // same-cycle inc and dec on r5
        drv(1, 0, 0, 2'b00, 8'h20, 0, 8'h00);
        drv(1, 0, 0, 2'b00, 8'h20, 0, 8'h00);
        drv(0, 0, 0, 2'b00, 8'h00, 1, 8'h20);
        chk("same_cycle_issue", o_submit, 1'b1);
        chk("same_cycle_pend5", o_pending, 8'h20);
        drv(0, 0, 0, 2'b00, 8'h00, 1, 8'h20);

        // saturation of r2
        for (int k = 0; k < 4; k++) drv(1, 0, 0, 2'b00, 8'h04, 0, 8'h00);
        idle();
        chk("sat_stalled", o_submit, 1'b0);
        idle();
        drv(0, 0, 0, 2'b00, 8'h00, 1, 8'h04);
        chk("sat_held_at_wb", o_submit, 1'b0);
        idle();
        chk("sat_issue", o_submit, 1'b1);
        for (int k = 0; k < 3; k++) drv(0, 0, 0, 2'b00, 8'h00, 1, 8'h04);
        chk("sat_drained", o_pending, 8'h00);

        // flush with a buffered instruction and a same-cycle submit
        drv(1, 0, 0, 2'b00, 8'h40, 0, 8'h00);
        i_submit = 1; i_rf_ie = 8'h40; i_flush = 1; i_next_ready = 1;
        i_wb_valid = 0; i_payload = 64'hdead_beef_0000_0001;
        step();
        chk("flush_no_submit", o_submit, 1'b0);
        chk("flush_counts", o_pending, 8'h00);
        idle();
        chk("flush_buf_empty", o_submit, 1'b0);

        // randomized traffic; writebacks drawn from the in-flight queue
        inflight.delete();
        for (int n = 0; n < 500; n++) begin
            i_submit = ($urandom_range(0, 3) != 0);
            i_payload = {$urandom, $urandom};
            i_l_reg_sel = 3'($urandom_range(0, 7));
            i_r_reg_sel = 3'($urandom_range(0, 7));
            i_used_operands = 2'($urandom_range(0, 3));
            i_rf_ie = ($urandom_range(0, 3) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
            i_next_ready = ($urandom_range(0, 4) != 0);
            i_flush = ($urandom_range(0, 19) == 0);
            if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
                i_wb_valid = 1; i_wb_rf_ie = inflight.pop_front();
            end else begin
                i_wb_valid = 0; i_wb_rf_ie = 8'h00;
            end
            step();
        end
        for (int n = 0; n < 60; n++) begin
            if (inflight.size() > 0) drv(0, 0, 0, 2'b00, 8'h00, 1, inflight.pop_front());
            else idle();
        end
        chk("rand_drained", o_pending, 8'h00);
        chk("rand_no_underflow", o_underflow, 1'b0);

        // underflow on r7, sticky
        drv(0, 0, 0, 2'b00, 8'h00, 1, 8'h80);
        chk("underflow_set", o_underflow, 1'b1);
        idle();
        chk("underflow_sticky", o_underflow, 1'b1);

        // async reset in the middle of a RAW stall
        drv(1, 0, 0, 2'b00, 8'h02, 0, 8'h00);
        drv(1, 1, 0, 2'b01, 8'h00, 0, 8'h00);
        idle();
        idle();
        #1 i_rst = 1'b1;
        #1;
        chk("arst_pending", o_pending, 8'h00);
        chk("arst_underflow", o_underflow, 1'b0);
        chk("arst_stall", o_stall_cnt, 16'h0);
        chk("arst_ready", o_ready, 1'b1);
        chk("arst_rf_ie", o_rf_ie, 8'h00);
        m_reset();
        #1 i_rst = 1'b0;
        idle();
        chk("post_rst_submit", o_submit, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
